// File: rtl/drink_pkg.sv
// drink_pkg
//   Definitions shared by the coin accumulator and the vending stage:
//   FSM state encoding, coin values in 10-cent units, the default price
//   and the coin-count saturation limit.
package drink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_OFFER  = 2'b10,
    ST_REFUND = 2'b11
  } state_t;

  localparam logic [7:0] HALF_VAL      = 8'd5;
  localparam logic [7:0] ONE_VAL       = 8'd10;
  localparam logic [7:0] DEFAULT_PRICE = 8'd25;
  localparam logic [1:0] COUNT_MAX     = 2'd3;

endpackage

// File: rtl/coin_counter.sv
// coin_counter
//   2-bit saturating coin counter, one instance per coin type.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   inc         : a coin of this type is offered this cycle
//   clear       : drop the held count to zero
//   hold        : freeze the count (wins over clear and inc)
//   count       : held count, 0..3
//   sat_reject  : combinational; an offered coin cannot be taken (count is 3)
module coin_counter
  import drink_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  input  logic       hold,
  output logic [1:0] count,
  output logic       sat_reject
);

  logic [1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
    end else if (hold) begin
      r_count <= r_count;
    end else if (clear) begin
      r_count <= 2'd0;
    end else if (inc && (r_count != COUNT_MAX)) begin
      r_count <= r_count + 2'd1;
    end
  end

  assign sat_reject = inc && !hold && (r_count == COUNT_MAX);
  assign count      = r_count;

endmodule

// File: rtl/coin_accumulator.sv
// coin_accumulator
//   Front end of the drink vending stage. Counts half-dollar and one-dollar
//   coin pulses (saturating at 3 each), offers the held counts once the
//   credit reaches PRICE, and refunds on cancel or on a coin-free timeout.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   ena                   : clock enable; state holds while low
//   coin_half, coin_one   : single-cycle coin pulses from the acceptor
//   cancel                : customer cancel request (level)
//   collect               : acknowledge from the vending stage
//   half_dollar, one_dollar : held coin counts
//   credit                : combinational value of the held counts
//   valid                 : counts offered (state OFFER)
//   refund                : one-cycle pulse, return held coins
//   reject_coin           : one-cycle pulse, return the offending coin
//   state                 : current FSM state
//
// state  | meaning
// IDLE   | no credit held, waiting for the first coin
// ACCUM  | collecting coins, timeout counter running
// OFFER  | price reached, counts offered and frozen until collect/cancel
// REFUND | one-cycle refund pulse, counts still visible to the dispenser
module coin_accumulator
  import drink_pkg::*;
#(
  parameter logic [7:0] PRICE   = DEFAULT_PRICE,
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       cancel,
  input  logic       collect,
  output logic [1:0] half_dollar,
  output logic [1:0] one_dollar,
  output logic [7:0] credit,
  output logic       valid,
  output logic       refund,
  output logic       reject_coin,
  output logic [1:0] state
);

  state_t     r_state;
  logic       r_valid;
  logic       r_refund;
  logic       r_reject;
  logic [7:0] r_timer;

  logic       w_taking;
  logic       w_inc_half;
  logic       w_inc_one;
  logic       w_clear;
  logic       w_sat_half;
  logic       w_sat_one;
  logic       w_add_half;
  logic       w_add_one;
  logic       w_any_add;
  logic       w_reject;
  logic [1:0] w_half;
  logic [1:0] w_one;
  logic [7:0] w_credit;
  logic [7:0] w_credit_nxt;

  // Coins are only offered to the counters while the FSM is collecting.
  assign w_taking   = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_inc_half = ena && w_taking && coin_half;
  assign w_inc_one  = ena && w_taking && coin_one;
  assign w_clear    = ena && (((r_state == ST_OFFER) && collect) || (r_state == ST_REFUND));

  coin_counter u_half_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc        (w_inc_half),
    .clear      (w_clear),
    .hold       (!ena),
    .count      (w_half),
    .sat_reject (w_sat_half)
  );

  coin_counter u_one_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc        (w_inc_one),
    .clear      (w_clear),
    .hold       (!ena),
    .count      (w_one),
    .sat_reject (w_sat_one)
  );

  assign w_add_half = w_inc_half && !w_sat_half;
  assign w_add_one  = w_inc_one && !w_sat_one;
  assign w_any_add  = w_add_half || w_add_one;

  assign w_credit     = (HALF_VAL * {6'd0, w_half}) + (ONE_VAL * {6'd0, w_one});
  // Credit as it will be after this edge, so OFFER is reached with no extra cycle.
  assign w_credit_nxt = w_credit + (w_add_half ? HALF_VAL : 8'd0)
                                 + (w_add_one  ? ONE_VAL  : 8'd0);

  assign w_reject = w_taking ? (w_sat_half || w_sat_one) : (coin_half || coin_one);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_refund <= 1'b0;
      r_reject <= 1'b0;
      r_timer  <= 8'd0;
    end else if (!ena) begin
      r_refund <= 1'b0;
      r_reject <= coin_half || coin_one;
    end else begin
      r_refund <= 1'b0;
      r_reject <= w_reject;
      case (r_state)
        ST_IDLE: begin
          r_timer <= 8'd0;
          if (w_any_add) begin
            if (w_credit_nxt >= PRICE) begin
              r_state <= ST_OFFER;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_credit_nxt >= PRICE) begin
            r_state <= ST_OFFER;
            r_valid <= 1'b1;
            r_timer <= 8'd0;
          end else if (cancel) begin
            r_state  <= ST_REFUND;
            r_refund <= 1'b1;
            r_timer  <= 8'd0;
          end else if (w_any_add) begin
            r_timer <= 8'd0;
          end else if (r_timer == TIMEOUT) begin
            r_state  <= ST_REFUND;
            r_refund <= 1'b1;
            r_timer  <= 8'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_OFFER: begin
          if (collect) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else if (cancel) begin
            r_state  <= ST_REFUND;
            r_valid  <= 1'b0;
            r_refund <= 1'b1;
          end
        end
        ST_REFUND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign half_dollar = w_half;
  assign one_dollar  = w_one;
  assign credit      = w_credit;
  assign valid       = r_valid;
  assign refund      = r_refund;
  assign reject_coin = r_reject;
  assign state       = r_state;

endmodule

// File: tb/tb_coin_accumulator.sv
module tb_coin_accumulator;

  localparam int TB_TIMEOUT = 4;
  localparam int P_IDLE = 0, P_ACCUM = 1, P_OFFER = 2, P_REFUND = 3;

  logic       clk;
  logic       reset, ena, coin_half, coin_one, cancel, collect;
  logic [1:0] half_dollar, one_dollar, state;
  logic [7:0] credit;
  logic       valid, refund, reject_coin;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: coin counts, phase (spec encoding), coin-free cycle count
  int m_half, m_one, m_phase, m_quiet;
  bit m_valid, m_refund, m_reject;

  coin_accumulator #(.PRICE(8'd25), .TIMEOUT(8'(TB_TIMEOUT))) dut (
    .clk(clk), .reset(reset), .ena(ena), .coin_half(coin_half), .coin_one(coin_one),
    .cancel(cancel), .collect(collect), .half_dollar(half_dollar), .one_dollar(one_dollar),
    .credit(credit), .valid(valid), .refund(refund), .reject_coin(reject_coin), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit e, input bit ch, input bit co,
                            input bit ca, input bit col);
    bit took;
    int cr;
    if (r) begin
      m_half = 0; m_one = 0; m_phase = P_IDLE; m_quiet = 0;
      m_valid = 0; m_refund = 0; m_reject = 0;
    end else if (!e) begin
      m_refund = 0;
      m_reject = ch | co;
    end else begin
      m_refund = 0; m_reject = 0; took = 0;
      if (m_phase == P_IDLE || m_phase == P_ACCUM) begin
        if (ch) begin if (m_half < 3) begin m_half++; took = 1; end else m_reject = 1; end
        if (co) begin if (m_one < 3) begin m_one++; took = 1; end else m_reject = 1; end
        cr = 5 * m_half + 10 * m_one;
        if (m_phase == P_IDLE) begin
          if (took) begin m_quiet = 0; m_phase = (cr >= 25) ? P_OFFER : P_ACCUM; end
        end else if (cr >= 25) m_phase = P_OFFER;
        else if (ca) begin m_phase = P_REFUND; m_refund = 1; end
        else if (took) m_quiet = 0;
        else if (m_quiet == TB_TIMEOUT) begin m_phase = P_REFUND; m_refund = 1; end
        else m_quiet++;
      end else if (m_phase == P_OFFER) begin
        m_reject = ch | co;
        if (col) begin m_half = 0; m_one = 0; m_phase = P_IDLE; end
        else if (ca) begin m_phase = P_REFUND; m_refund = 1; end
      end else begin
        m_reject = ch | co;
        m_half = 0; m_one = 0; m_phase = P_IDLE;
      end
      if (m_phase != P_ACCUM) m_quiet = 0;
      m_valid = (m_phase == P_OFFER);
    end
  endtask

  // apply inputs, clock one edge, advance the model, settle past the edge
  task automatic drive(input bit r, input bit e, input bit ch, input bit co,
                       input bit ca, input bit col);
    reset = r; ena = e; coin_half = ch; coin_one = co; cancel = ca; collect = col;
    @(posedge clk);
    model_step(r, e, ch, co, ca, col);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1, 1, 1);
    drive(1, 1, 0, 0, 0, 0);
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (credit !== 8'd0) begin n_errors++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    n_checks++; if (half_dollar !== 2'd0 || one_dollar !== 2'd0) begin n_errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", half_dollar, one_dollar); end
    n_checks++; if ({valid, refund, reject_coin} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got=%b exp=000", {valid, refund, reject_coin}); end
  endtask

  task automatic test_exact_price();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    n_checks++; if (credit !== 8'd10 || state !== 2'd1) begin n_errors++; $display("FAIL exact_first credit=%0d state=%0d exp=10/1", credit, state); end
    drive(0, 1, 0, 1, 0, 0);
    n_checks++; if (credit !== 8'd20 || valid !== 1'b0) begin n_errors++; $display("FAIL exact_second credit=%0d valid=%0d exp=20/0", credit, valid); end
    drive(0, 1, 1, 0, 0, 0);
    n_checks++; if (credit !== 8'd25 || valid !== 1'b1 || state !== 2'd2) begin n_errors++; $display("FAIL exact_offer credit=%0d valid=%0d state=%0d exp=25/1/2", credit, valid, state); end
    n_checks++; if (half_dollar !== 2'd1 || one_dollar !== 2'd2) begin n_errors++; $display("FAIL exact_counts got=%0d/%0d exp=1/2", half_dollar, one_dollar); end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (valid !== 1'b1 || credit !== 8'd25) begin n_errors++; $display("FAIL exact_held valid=%0d credit=%0d exp=1/25", valid, credit); end
    drive(0, 1, 0, 0, 0, 1);
  endtask

  task automatic test_overpay();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    n_checks++; if (credit !== 8'd35 || valid !== 1'b1 || reject_coin !== 1'b0) begin n_errors++; $display("FAIL overpay_offer credit=%0d valid=%0d rej=%0d exp=35/1/0", credit, valid, reject_coin); end
    drive(0, 1, 0, 0, 1, 1);
    n_checks++; if (state !== 2'd0 || credit !== 8'd0 || valid !== 1'b0 || refund !== 1'b0) begin n_errors++; $display("FAIL overpay_collect state=%0d credit=%0d valid=%0d refund=%0d exp=0/0/0/0", state, credit, valid, refund); end
  endtask

  task automatic test_cancel();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0);
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL cancel_idle_ignored state=%0d exp=0", state); end
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0);
    n_checks++; if (credit !== 8'd15) begin n_errors++; $display("FAIL cancel_credit got=%0d exp=15", credit); end
    drive(0, 1, 0, 0, 1, 0);
    n_checks++; if (refund !== 1'b1 || half_dollar !== 2'd3 || state !== 2'd3) begin n_errors++; $display("FAIL cancel_refund refund=%0d half=%0d state=%0d exp=1/3/3", refund, half_dollar, state); end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (refund !== 1'b0 || credit !== 8'd0 || state !== 2'd0) begin n_errors++; $display("FAIL cancel_after refund=%0d credit=%0d state=%0d exp=0/0/0", refund, credit, state); end
  endtask

  task automatic test_timeout();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= TB_TIMEOUT + 1; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      n_checks++;
      if (k <= TB_TIMEOUT) begin
        if (refund !== 1'b0 || state !== 2'd1 || valid !== 1'b0) begin n_errors++; $display("FAIL timeout_wait k=%0d refund=%0d state=%0d valid=%0d exp=0/1/0", k, refund, state, valid); end
      end else begin
        if (refund !== 1'b1 || state !== 2'd3 || valid !== 1'b0) begin n_errors++; $display("FAIL timeout_fire refund=%0d state=%0d valid=%0d exp=1/3/0", refund, state, valid); end
      end
    end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (refund !== 1'b0 || state !== 2'd0) begin n_errors++; $display("FAIL timeout_after refund=%0d state=%0d exp=0/0", refund, state); end
  endtask

  task automatic test_saturation();
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      n_checks++; if (reject_coin !== 1'b0) begin n_errors++; $display("FAIL sat_early_reject i=%0d got=%0d exp=0", i, reject_coin); end
    end
    drive(0, 1, 1, 0, 0, 0);
    n_checks++; if (reject_coin !== 1'b1 || half_dollar !== 2'd3 || credit !== 8'd15) begin n_errors++; $display("FAIL sat_fourth rej=%0d half=%0d credit=%0d exp=1/3/15", reject_coin, half_dollar, credit); end
    drive(0, 1, 0, 1, 0, 0);
    n_checks++; if (reject_coin !== 1'b0 || credit !== 8'd25 || state !== 2'd2) begin n_errors++; $display("FAIL sat_offer rej=%0d credit=%0d state=%0d exp=0/25/2", reject_coin, credit, state); end
    drive(0, 1, 1, 0, 0, 0);
    n_checks++; if (reject_coin !== 1'b1 || half_dollar !== 2'd3 || one_dollar !== 2'd1 || valid !== 1'b1) begin n_errors++; $display("FAIL sat_offer_reject rej=%0d counts=%0d/%0d valid=%0d exp=1/3/1/1", reject_coin, half_dollar, one_dollar, valid); end
    drive(0, 1, 0, 0, 0, 1);
  endtask

  task automatic test_reset_enable();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0);
    n_checks++; if (state !== 2'd0 || credit !== 8'd0 || valid !== 1'b0 || refund !== 1'b0) begin n_errors++; $display("FAIL rst_offer state=%0d credit=%0d valid=%0d refund=%0d exp=0/0/0/0", state, credit, valid, refund); end
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    n_checks++; if (reject_coin !== 1'b1 || credit !== 8'd10 || state !== 2'd1 || refund !== 1'b0) begin n_errors++; $display("FAIL ena_low_coin rej=%0d credit=%0d state=%0d refund=%0d exp=1/10/1/0", reject_coin, credit, state, refund); end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++; if (reject_coin !== 1'b0 || credit !== 8'd10) begin n_errors++; $display("FAIL ena_low_idle rej=%0d credit=%0d exp=0/10", reject_coin, credit); end
  endtask

  task automatic test_random();
    bit r, e, ch, co, ca, col;
    drive(1, 1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 79) == 0);
      e   = ($urandom_range(0, 7) != 0);
      ch  = ($urandom_range(0, 3) == 0);
      co  = ($urandom_range(0, 4) == 0);
      ca  = ($urandom_range(0, 15) == 0);
      col = ($urandom_range(0, 2) == 0);
      drive(r, e, ch, co, ca, col);
      n_checks++; if (state !== 2'(m_phase)) begin n_errors++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, state, m_phase); end
      n_checks++; if (half_dollar !== 2'(m_half) || one_dollar !== 2'(m_one)) begin n_errors++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, half_dollar, one_dollar, m_half, m_one); end
      n_checks++; if (credit !== 8'(5 * m_half + 10 * m_one)) begin n_errors++; $display("FAIL rnd_credit n=%0d got=%0d exp=%0d", n, credit, 5 * m_half + 10 * m_one); end
      n_checks++; if ({valid, refund, reject_coin} !== {m_valid, m_refund, m_reject}) begin n_errors++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {valid, refund, reject_coin}, {m_valid, m_refund, m_reject}); end
    end
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0; collect = 1'b0;
    test_reset();
    test_exact_price();
    test_overpay();
    test_cancel();
    test_timeout();
    test_saturation();
    test_reset_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
